regfile_write_bank: RTL
=======================

# regfile_write_bank

32-entry × 32-bit register bank with a decoded write port: the write-side counterpart to the 32:1 × 32-bit read multiplexer.
- A 5-bit write address is decoded one-hot, and the addressed register captures write data on the clock edge.
- All 32 register contents are exported as one flat bus that feeds the read multiplexer's 32 inputs.
- A sequenced clear command zeroes the bank one register per cycle under a busy flag.
- Register 0 is hardwired to zero.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- ADDRW, 5, address width; depth is 2^ADDRW = 32

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write request, sampled on the rising edge of clk
- wr_addr  input  ADDRW  target register index
- wr_data  input  WIDTH  data to store
- clear_req  input  1  request to zero all registers sequentially
- wr_ack  output  1  one-cycle pulse confirming an accepted write
- busy  output  1  high while a clear sequence is in progress
- wr_onehot  output  2^ADDRW  combinational one-hot decode of wr_addr, gated by wr_en && !busy
- regs  output  WIDTH·2^ADDRW  flat register contents; register i occupies bits [i·WIDTH +: WIDTH]

## Operation
- Storage: 31 physical registers, indices 1..31. Index 0 is not stored; regs[WIDTH-1:0] is constant 0.
- Decoder: wr_onehot[i] = wr_en && !busy && (wr_addr == i), for every i including 0.
- Write acceptance: at an edge where state is IDLE and wr_en = 1, register wr_addr ← wr_data.
  - A write to address 0 is accepted, but has no storage effect.
- Write acknowledge: wr_ack is registered. It is 1 for exactly the cycle after any accepted write (address 0 included), and 0 otherwise.
  - Back-to-back writes produce a continuous run of wr_ack.
- State machine: two states, IDLE and CLEAR; busy = (state == CLEAR).
  - IDLE → CLEAR: clear_req = 1 at an edge. The clear counter is loaded with 1.
  - CLEAR: each edge zeroes register[counter], then increments the counter.
  - CLEAR → IDLE: at the edge that zeroes register 31. The counter wraps to 0 and is unused in IDLE.
  - Total: a clear occupies exactly 31 busy cycles.
- In CLEAR:
  - wr_en is ignored: no storage change, no wr_ack, wr_onehot all zero.
  - clear_req is ignored and is not queued.
- Simultaneous wr_en and clear_req in IDLE: the write is performed, and wr_ack pulses next cycle. The clear starts on that same edge, so the written register is later zeroed (unless it is register 0).
- clear_req held high continuously: a new clear begins on the edge after busy falls, i.e. one IDLE cycle between sequences. A write may be accepted in that IDLE cycle.
- Reset:
  - All registers are 0, state = IDLE, counter = 0, wr_ack = 0, busy = 0.
  - Reset overrides any in-progress clear or write on the same edge.

## Timing
- Write latency: data visible on regs one cycle after the accepting edge, i.e. immediately after the clock edge, in the same cycle that wr_ack is high.
- busy rises the cycle after clear_req is sampled and stays high for 31 cycles.
- Register k (1..31) reads 0 from the end of busy-cycle k onward.
- Throughput: one write per cycle in IDLE; no bubbles.
- The regs output is a direct register read with no added combinational delay. Only wr_onehot is combinational.

## Test plan
- Reset, then write 0xDEADBEEF to address 5 → next cycle:
  - regs[5·32 +: 32] = 0xDEADBEEF
  - wr_ack = 1 for one cycle
  - all other registers still 0
- Write 0xFFFFFFFF to address 0 → wr_ack pulses; regs[31:0] stays 0x00000000.
- Fill registers 1..31 with the value i·0x01010101 on back-to-back cycles → wr_ack is high 31 consecutive cycles, and every slice matches.
- From the filled state, pulse clear_req →
  - busy is high for exactly 31 cycles
  - register 10 still holds 0x0A0A0A0A after busy-cycle 9 and reads 0 after busy-cycle 10
  - all registers are 0 when busy falls
- During a clear, assert wr_en with address 3 and data 0x12345678 → no wr_ack, wr_onehot = 0, register 3 ends at 0.
- Assert reset at busy-cycle 15 of a clear → next cycle busy = 0, all registers 0. A subsequent write to address 31 succeeds normally.

Source files
------------

// File: rtl/regfile_write_bank.sv
// 32 x WIDTH register bank with a decoded write port and a sequenced clear.
// Register 0 reads as zero; the flat regs bus feeds the 32:1 read multiplexer.

module regfile_write_bank_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset || clr) r_q <= '0;
    else if (we)      r_q <= d;
  end

  assign q = r_q;
endmodule

module regfile_write_bank #(
  parameter int WIDTH = 32,
  parameter int ADDRW = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ADDRW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         clear_req,
  output logic                         wr_ack,
  output logic                         busy,
  output logic [(2**ADDRW)-1:0]        wr_onehot,
  output logic [WIDTH*(2**ADDRW)-1:0]  regs
);
  localparam int DEPTH = 2**ADDRW;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           r_state;
  logic [ADDRW-1:0] r_cnt;
  logic             r_ack;
  logic [DEPTH-1:1] w_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= wr_en;
          if (clear_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= ADDRW'(1);
          end
        end
        S_CLEAR: begin
          // Counter wraps to 0 on the edge that clears the last register.
          r_ack <= 1'b0;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {ADDRW{1'b1}}) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = (r_state == S_CLEAR);
  assign wr_ack = r_ack;

  always_comb begin
    wr_onehot = '0;
    if (wr_en && !busy) wr_onehot[wr_addr] = 1'b1;
  end

  assign regs[WIDTH-1:0] = '0;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
    assign w_clr[gi] = busy && (r_cnt == ADDRW'(gi));
    regfile_write_bank_cell #(.WIDTH(WIDTH)) u_cell (
      .clk   (clk),
      .reset (reset),
      .we    (wr_onehot[gi]),
      .clr   (w_clr[gi]),
      .d     (wr_data),
      .q     (regs[gi*WIDTH +: WIDTH])
    );
  end
endmodule
